// File: rtl/vga_config_master_pkg.sv
// rtl/vga_config_master_pkg.sv - shared VGA mode codes, config address and FSM state encoding
package vga_config_master_pkg;

  typedef enum logic [1:0] {
    R6X4         = 2'b00,
    R8X6         = 2'b01,
    R10X7        = 2'b10,
    MODE_ILLEGAL = 2'b11
  } vga_mode_e;

  localparam logic [7:0] ADDR_VGA_CONFIG_DEFAULT = 8'h00;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT_RDY
  } cfg_state_e;

  function automatic logic mode_legal(input logic [1:0] mode);
    return mode != MODE_ILLEGAL;
  endfunction

endpackage

// File: rtl/vga_cfg_timeout.sv
// rtl/vga_cfg_timeout.sv - loadable up-counter with clear, enable and expired flag
module vga_cfg_timeout
  import vga_config_master_pkg::*;
#(
  parameter int TIMEOUT  = 16,
  parameter int TO_WIDTH = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic                load,
  input  logic [TO_WIDTH-1:0] load_value,
  input  logic                enable,
  output logic                expired
);

  logic [TO_WIDTH-1:0] count;

  // expired marks the TIMEOUT-th enabled cycle, so the owner acts on that same edge
  assign expired = (count == TO_WIDTH'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (enable && !expired) begin
      count <= count + TO_WIDTH'(1);
    end
  end

endmodule

// File: rtl/vga_config_master.sv
// rtl/vga_config_master.sv - config bus initiator: one resolution write per request with ack timeout and retry
module vga_config_master
  import vga_config_master_pkg::*;
#(
  parameter int                      CONFIG_WIDTH    = 8,
  parameter logic [CONFIG_WIDTH-1:0] ADDR_VGA_CONFIG = CONFIG_WIDTH'(ADDR_VGA_CONFIG_DEFAULT),
  parameter int                      TIMEOUT         = 16,
  parameter int                      MAX_RETRY       = 3,
  parameter int                      TO_WIDTH        = 5
) (
  input  logic                    Clk,
  input  logic                    Rst,
  input  logic                    Req_valid,
  input  logic [1:0]              Req_mode,
  input  logic                    Req_force,
  input  logic                    C_rdy,
  output logic                    C_valid,
  output logic [CONFIG_WIDTH-1:0] C_addr,
  output logic [CONFIG_WIDTH-1:0] C_data,
  output logic                    Busy,
  output logic                    Done,
  output logic                    Err,
  output logic [1:0]              Cur_mode
);

  localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  cfg_state_e  state;
  logic [1:0]  mode_q;
  logic [RW-1:0] retry_q;
  logic        pend_valid;
  logic [1:0]  pend_mode;
  logic        pend_force;

  logic [1:0]  sel_mode;
  logic        sel_force;
  logic        take;
  logic        pend_wr;
  logic        pend_n;
  logic        to_expired;

  // The held request outranks a fresh strobe; a strobe that cannot be served now lands in the buffer.
  always_comb begin
    sel_mode  = pend_valid ? pend_mode  : Req_mode;
    sel_force = pend_valid ? pend_force : Req_force;
    take      = (state == ST_IDLE) && (pend_valid || Req_valid);
    pend_wr   = Req_valid && ((state != ST_IDLE) || pend_valid);
    pend_n    = pend_wr || (pend_valid && !take);
  end

  vga_cfg_timeout #(
    .TIMEOUT  (TIMEOUT),
    .TO_WIDTH (TO_WIDTH)
  ) u_timeout (
    .clk        (Clk),
    .rst        (Rst),
    .clear      (state == ST_SEND),
    .load       (1'b0),
    .load_value ('0),
    .enable     ((state == ST_WAIT_RDY) && !C_rdy),
    .expired    (to_expired)
  );

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state      <= ST_IDLE;
      mode_q     <= R6X4;
      retry_q    <= '0;
      pend_valid <= 1'b0;
      pend_mode  <= R6X4;
      pend_force <= 1'b0;
      C_valid    <= 1'b0;
      C_addr     <= '0;
      C_data     <= '0;
      Busy       <= 1'b0;
      Done       <= 1'b0;
      Err        <= 1'b0;
      Cur_mode   <= R6X4;
    end else begin
      Done       <= 1'b0;
      Err        <= 1'b0;
      pend_valid <= pend_n;
      if (pend_wr) begin
        pend_mode  <= Req_mode;
        pend_force <= Req_force;
      end

      case (state)
        ST_IDLE: begin
          Busy <= pend_n;
          if (take) begin
            if (!mode_legal(sel_mode)) begin
              Err <= 1'b1;
            end else if ((sel_mode == Cur_mode) && !sel_force) begin
              Done <= 1'b1;
            end else begin
              mode_q  <= sel_mode;
              retry_q <= '0;
              state   <= ST_SEND;
              C_valid <= 1'b1;
              C_addr  <= ADDR_VGA_CONFIG;
              C_data  <= CONFIG_WIDTH'(sel_mode);
              Busy    <= 1'b1;
            end
          end
        end

        ST_SEND: begin
          C_valid <= 1'b0;
          C_addr  <= '0;
          C_data  <= '0;
          state   <= ST_WAIT_RDY;
          Busy    <= 1'b1;
        end

        ST_WAIT_RDY: begin
          if (C_rdy) begin
            Cur_mode <= mode_q;
            Done     <= 1'b1;
            state    <= ST_IDLE;
            Busy     <= pend_n;
          end else if (to_expired) begin
            if (retry_q < RW'(MAX_RETRY)) begin
              retry_q <= retry_q + RW'(1);
              state   <= ST_SEND;
              C_valid <= 1'b1;
              C_addr  <= ADDR_VGA_CONFIG;
              C_data  <= CONFIG_WIDTH'(mode_q);
              Busy    <= 1'b1;
            end else begin
              Err   <= 1'b1;
              state <= ST_IDLE;
              Busy  <= pend_n;
            end
          end else begin
            Busy <= 1'b1;
          end
        end

        default: begin
          state <= ST_IDLE;
          Busy  <= pend_n;
        end
      endcase
    end
  end

endmodule
